seq_player: RTL
===============

# seq_player

Plays back the stored round sequence to the player. On `start` it snapshots the 64-bit sequence word from the sequence register, then drives the LED nibble one symbol at a time, MSB nibble first, for `round+1` symbols. Each symbol is shown for `ON_CYCLES` cycles, followed by a blank gap of `OFF_CYCLES` cycles. It sits between the sequence register and the LED outputs, and the game controller starts it at the beginning of every round.

## Interface
- `ON_CYCLES`, default 25_000_000: cycles each symbol is lit; legal range ≥ 1.
- `OFF_CYCLES`, default 12_500_000: blank cycles after each symbol; legal range ≥ 1.
- `clk` input 1: single clock; all logic is on its rising edge.
- `R` input 1: reset, synchronous, active-high.
- `start` input 1: request playback; sampled only in IDLE.
- `data` input 64: sequence word; symbol k = `data[63-4k -: 4]`.
- `round` input 4: number of symbols to play minus 1 (0 → 1 symbol, 15 → 16 symbols).
- `led` output 4: current symbol; 4'b0000 when blank or idle.
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: one-cycle pulse after the final gap.

## Operation
- States are IDLE, SHOW, GAP and FIN.
- **IDLE**
  - `led`=0, `busy`=0, `done`=0.
  - `start`=1 on an edge: latch `data` into the internal 64-bit `seq_q`, latch `round` into `last_q`, set index=0, load timer=ON_CYCLES-1, go to SHOW.
- **SHOW**
  - `led` = `seq_q[63:60]`. The shadow shifts left by 4 on each SHOW→GAP exit, so the head nibble is always at the top.
  - When the timer reaches 0, go to GAP and load timer=OFF_CYCLES-1.
- **GAP**
  - `led`=0.
  - When the timer reaches 0:
    - if index == `last_q`, go to FIN;
    - otherwise index+1, go to SHOW, load timer=ON_CYCLES-1.
- **FIN**
  - `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- `start` is ignored in SHOW, GAP and FIN. There is no queuing.
- Changes to `data` and `round` after acceptance have no effect, because the shadow copies are used.
- The index is 4 bits wide. With `last_q`=15, playback ends after index 15 and the index never wraps.
- `R`=1 on any edge forces IDLE, `led`=0, `busy`=0, `done`=0, and clears the timer, index and shadow. R has priority over `start` in the same cycle.
- The timer is a down-counter of width `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1 bit. It reloads on every state entry.

## Timing
- All outputs are registered. Reset value of every output is 0.
- With `start` accepted at edge t0:
  - SHOW occupies cycles t0+1 … t0+ON_CYCLES;
  - GAP occupies the next OFF_CYCLES cycles.
- One symbol period = ON_CYCLES+OFF_CYCLES cycles.
- `done` is high at cycle t0 + (round+1)·(ON_CYCLES+OFF_CYCLES) + 1.
- A new `start` is accepted at the earliest in the cycle after `done`. A `start` held high through FIN is accepted on the first IDLE edge.

## Structure
- Shared package `game_pkg`:
  - state enum (IDLE/SHOW/GAP/FIN);
  - `SYM_W`=4, `SEQ_W`=64, `N_SYM`=16.
  - The sequence register and the input checker also use these constants.
- Sub-module `seq_timer`: a loadable down-counter with `load`, `value` and `zero` outputs, parameterised on width. It is reused by the input-timeout logic.
- `seq_player` contains the FSM, the shadow shift register and the index counter. Target size is about 150 lines.

## Test plan
Run all scenarios with ON_CYCLES=3 and OFF_CYCLES=2.
- **Single symbol:** `data`=64'hA000_0000_0000_0000, `round`=0, pulse `start` → `led`=4'hA for 3 cycles, then 0 for 2 cycles; `done` pulses at t0+6; `busy` is high t0+1…t0+6.
- **Full round:** `data`=64'h0123_4567_89AB_CDEF, `round`=15 → `led` sequence 0,1,…,F. Each symbol lasts 3 cycles with a 2-cycle gap between symbols. `done` fires at t0+81, and the index does not wrap.
- **Input isolation:** `round`=2, `data`=64'h8421_…; change `data` to all-F and `start` to 1 during playback → the output is still 8,4,2. `done` fires once at t0+16, and there is no second playback until `start` is sampled in IDLE.
- **Reset mid-play:** assert `R` in the 2nd cycle of symbol 1 → on the next edge `led`=0, `busy`=0, `done`=0 and the state is IDLE. The following `start` replays from symbol 0.
- **Simultaneous R and start:** `R`=1 and `start`=1 on the same edge → the block stays IDLE and no playback begins.
- **Back-to-back:** hold `start`=1 continuously with `round`=1 → playbacks run with exactly one IDLE cycle between `done` and the next SHOW.

Source files
------------

// File: rtl/game_pkg.sv
// Constants and state encoding shared by the sequence register, the input
// checker and the sequence player.
package game_pkg;

    localparam int SYM_W = 4;
    localparam int SEQ_W = 64;
    localparam int N_SYM = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_player_if.sv
// Player handshake and LED bus: the controller drives start/data/round,
// the player returns led/busy/done.
interface seq_player_if;
    import game_pkg::*;

    logic             start;
    logic [SEQ_W-1:0] data;
    logic [3:0]       round;
    logic [SYM_W-1:0] led;
    logic             busy;
    logic             done;

    modport master (output start, data, round, input led, busy, done);
    modport slave  (input start, data, round, output led, busy, done);
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter that stops at zero; also used by the input-timeout logic.
module seq_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i)
            value_d = load_val_i;
        else if (value_q != '0)
            value_d = value_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/seq_player.sv
// Plays round+1 symbols of a snapshotted sequence word on the LEDs, MSB
// nibble first, each lit ON_CYCLES then blanked OFF_CYCLES.
module seq_player
    import game_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input logic         clk,
    input logic         R,
    seq_player_if.slave bus
);

    localparam int MAXC  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDX_W = $clog2(N_SYM);
    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);

    state_e           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [SYM_W-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic [TW-1:0]    tmr_value;
    logic             tmr_zero;

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_i      (R),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        last_d   = last_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                seq_d    = bus.data;
                last_d   = bus.round;
                idx_d    = '0;
                tmr_load = 1'b1;
                tmr_val  = ON_LD;
                state_d  = SHOW;
            end
            SHOW: if (tmr_zero) begin
                // Shift on exit so the next symbol is already at the top.
                seq_d    = {seq_q[SEQ_W-SYM_W-1:0], SYM_W'(0)};
                tmr_load = 1'b1;
                tmr_val  = OFF_LD;
                state_d  = GAP;
            end
            GAP: if (tmr_zero) begin
                if (idx_q == last_q) begin
                    state_d = FIN;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = ON_LD;
                    state_d  = SHOW;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from next state so they are registered yet aligned.
        led_d  = (state_d == SHOW) ? seq_d[SEQ_W-1 -: SYM_W] : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            seq_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The timer is always drained by the time playback returns to IDLE.
    a_idle_timer_clear: assert property (@(posedge clk) disable iff (R)
        (state_q == IDLE) |-> (tmr_value == '0));

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
